// File: rtl/conv_window_gen.sv
// conv_window_gen
//
// Builds K x K stride-1 sliding windows (no padding) from a raster-order pixel
// stream. The packed window layout matches the conv stage's idata input, so
// odata can be wired straight into it.
//
// Ports:
//   clk     rising-edge clock
//   rstn    asynchronous active-low reset
//   ivalid  idata carries a pixel
//   iready  a pixel is taken this cycle when ivalid is also high
//   idata   signed pixel, raster order
//   ovalid  odata holds a complete window
//   oready  downstream takes the window this cycle
//   odata   window; element i = r*K + c at [i*DATA_WIDTH +: DATA_WIDTH],
//           r = 0 oldest row, c = 0 oldest column, element K*K-1 newest pixel
//   olast   marks the last window of a frame
//
// Build option:
//   CONV_WIN_CLAMP_EN  when defined, the most negative pixel code is replaced
//                      by the next code up before storage, so the conv stage
//                      can negate any stored pixel without overflow.
module conv_window_gen #(
  parameter int DATA_WIDTH = 4,
  parameter int K          = 4,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         ivalid,
  output logic                         iready,
  input  logic signed [DATA_WIDTH-1:0] idata,
  output logic                         ovalid,
  input  logic                         oready,
  output logic [K*K*DATA_WIDTH-1:0]    odata,
  output logic                         olast
);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int WIN_W = K*K*DATA_WIDTH;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W-1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H-1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K-1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K-1);

  logic [CW-1:0]                  col;
  logic [RW-1:0]                  row;
  logic                           accept;
  logic                           win_done;
  logic                           frame_end;
  logic signed [DATA_WIDTH-1:0]   pix_p0;
  logic [K-1:0][DATA_WIDTH-1:0]   col_in;
  logic [WIN_W-1:0]               win_p0;
  logic [WIN_W-1:0]               win_nxt;

  function automatic logic signed [DATA_WIDTH-1:0] clamp_pix(
    input logic signed [DATA_WIDTH-1:0] p
  );
`ifdef CONV_WIN_CLAMP_EN
    logic signed [DATA_WIDTH-1:0] most_neg;
    most_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    return (p == most_neg) ? (most_neg | DATA_WIDTH'(1)) : p;
`else
    return p;
`endif
  endfunction

  // Output register is one deep: room exists when empty or being drained.
  assign iready    = !ovalid || oready;
  assign accept    = ivalid && iready;
  assign pix_p0    = clamp_pix(idata);
  assign win_done  = (row >= ROW_FIRST) && (col >= COL_FIRST);
  assign frame_end = (row == ROW_LAST) && (col == COL_LAST);

  // ---- stage p0: line buffers feed the new right-hand window column ----
  // Buffer 0 holds the oldest row. Each accept shifts the column at address
  // col up by one buffer, so every buffer is rewritten in place.
  for (genvar j = 0; j < K-1; j++) begin : g_lbuf
    logic signed [DATA_WIDTH-1:0] mem [IMG_W];
    logic signed [DATA_WIDTH-1:0] wr;
    if (j == K-2) begin : g_newest
      assign wr = pix_p0;
    end else begin : g_older
      assign wr = col_in[j+1];
    end
    always_ff @(posedge clk) begin
      if (accept) begin
        mem[col] <= wr;
      end
    end
    assign col_in[j] = mem[col];
  end
  assign col_in[K-1] = pix_p0;

  always_comb begin
    win_nxt = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K-1; c++) begin
        win_nxt[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] =
          win_p0[(r*K+c+1)*DATA_WIDTH +: DATA_WIDTH];
      end
      win_nxt[(r*K+K-1)*DATA_WIDTH +: DATA_WIDTH] = col_in[r];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      win_p0 <= win_nxt;
    end
  end

  // ---- stage p1: counters and output register ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col    <= '0;
      row    <= '0;
      ovalid <= 1'b0;
      olast  <= 1'b0;
      odata  <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      ovalid <= win_done;
      olast  <= win_done && frame_end;
      if (win_done) begin
        odata <= win_nxt;
      end
    end else if (oready) begin
      ovalid <= 1'b0;
      olast  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Testbench for conv_window_gen: drives raster frames (ramp and random images,
// random ivalid/oready gaps, a forced stall, resets) and compares every
// transferred window against windows cut directly out of the source image.
module tb_conv_window_gen;
  localparam int DW = 4;
  localparam int K  = 4;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int NW = (W-K+1)*(H-K+1);
  localparam int OW = K*K*DW;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 ivalid = 1'b0;
  logic                 oready = 1'b0;
  logic signed [DW-1:0] idata = '0;
  logic                 iready;
  logic                 ovalid;
  logic                 olast;
  logic [OW-1:0]        odata;

  conv_window_gen #(.DATA_WIDTH(DW), .K(K), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rstn(rstn), .ivalid(ivalid), .iready(iready), .idata(idata),
    .ovalid(ovalid), .oready(oready), .odata(odata), .olast(olast)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic signed [DW-1:0] img [H][W];
  logic [OW-1:0] exp_win[$];
  bit            exp_last[$];
  logic [OW-1:0] obs_win[$];
  bit            obs_last[$];
  int            acc_cyc[$];
  int            cyc;
  int            stall_cyc;
  bit            cyc_ov   [4096];
  bit            cyc_last [4096];
  bit            cyc_ird  [4096];
  logic [OW-1:0] cyc_dat  [4096];

  // Value the block is expected to store for an input pixel.
  function automatic logic signed [DW-1:0] stored(input logic signed [DW-1:0] p);
`ifdef CONV_WIN_CLAMP_EN
    if (p == 4'sb1000) return 4'sb1001;
`endif
    return p;
  endfunction

  // Every window of the frame, cut out of img in raster order of its newest pixel.
  function automatic void build_expected();
    exp_win.delete();
    exp_last.delete();
    for (int r = K-1; r < H; r++) begin
      for (int c = K-1; c < W; c++) begin
        logic [OW-1:0] w;
        w = '0;
        for (int i = 0; i < K*K; i++)
          w[i*DW +: DW] = stored(img[r-K+1+i/K][c-K+1+i%K]);
        exp_win.push_back(w);
        exp_last.push_back(r == H-1 && c == W-1);
      end
    end
  endfunction

  function automatic void set_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = DW'((r+c) % 7);
  endfunction

  function automatic void set_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = DW'($urandom);
  endfunction

  function automatic void clear_rec();
    obs_win.delete();
    obs_last.delete();
    acc_cyc.delete();
    cyc = 0;
    stall_cyc = -1;
  endfunction

  // Streams npix pixels of img (raster order). Samples DUT outputs each
  // negedge, then sets inputs for the coming posedge. Records transferred
  // windows, accept cycles and per-cycle output state. Leaves ivalid=0 and
  // oready=0 on return so nothing moves between calls.
  task automatic drive(input int npix, input int vpct, input int rpct,
                       input bit drain, input int stall_at, output bit to);
    int sent = 0;
    int stall_left = 0;
    bit stalled = 0;
    int budget = 3000;
    to = 0;
    forever begin
      @(negedge clk);
      cyc++;
      cyc_ov[cyc]   = ovalid;
      cyc_dat[cyc]  = odata;
      cyc_last[cyc] = olast;
      if (sent >= npix && (!drain || !ovalid)) begin
        ivalid = 0; oready = 0; break;
      end
      budget--;
      if (budget == 0) begin
        to = 1; ivalid = 0; oready = 0; break;
      end
      if (stall_at >= 0 && !stalled && stall_left == 0 && ovalid &&
          obs_win.size() == stall_at) begin
        stalled = 1; stall_left = 5; stall_cyc = cyc;
      end
      if (stall_left > 0) begin
        oready = 0; stall_left--;
      end else begin
        oready = ($urandom_range(99) < rpct);
      end
      ivalid = (sent < npix) && ($urandom_range(99) < vpct);
      if (ivalid) idata = img[sent/W][sent%W];
      else        idata = DW'($urandom);
      #1;
      cyc_ird[cyc] = iready;
      if (ovalid && oready) begin
        obs_win.push_back(odata);
        obs_last.push_back(olast);
      end
      if (ivalid && iready) begin
        acc_cyc.push_back(cyc);
        sent++;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 0; ivalid = 0; oready = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (ovalid !== 1'b0) $display("FAIL reset_ovalid got %b want 0", ovalid); else n_pass++;
    n_checks++; if (olast !== 1'b0) $display("FAIL reset_olast got %b want 0", olast); else n_pass++;
    n_checks++; if (odata !== '0) $display("FAIL reset_odata got %h want 0", odata); else n_pass++;
    n_checks++; if (iready !== 1'b1) $display("FAIL reset_iready got %b want 1", iready); else n_pass++;
    rstn = 1;
  endtask

  task automatic test_stream();
    bit to;
    logic [OW-1:0] wf;
    set_ramp(); build_expected(); clear_rec();
    drive(W*H, 100, 100, 1, -1, to);
    n_checks++; if (to) $display("FAIL stream_timeout got timeout want done"); else n_pass++;
    n_checks++; if (obs_win.size() != NW) $display("FAIL stream_count got %0d want %0d", obs_win.size(), NW); else n_pass++;
    for (int k = 0; k < obs_win.size() && k < NW; k++) begin
      n_checks++; if (obs_win[k] !== exp_win[k]) $display("FAIL stream_win%0d got %h want %h", k, obs_win[k], exp_win[k]); else n_pass++;
      n_checks++; if (obs_last[k] !== exp_last[k]) $display("FAIL stream_last%0d got %b want %b", k, obs_last[k], exp_last[k]); else n_pass++;
    end
    wf = '0;
    for (int i = 0; i < K*K; i++) wf[i*DW +: DW] = DW'((i/K + i%K) % 7);
    n_checks++; if (obs_win.size() == 0 || obs_win[0] !== wf) $display("FAIL stream_first_window got %h want %h", obs_win.size() ? obs_win[0] : '0, wf); else n_pass++;
    n_checks++; if (acc_cyc.size() != W*H) $display("FAIL stream_accepts got %0d want %0d", acc_cyc.size(), W*H); else n_pass++;
    for (int k = 0; k < acc_cyc.size(); k++) begin
      bit want;
      want = ((k%(W*H))/W >= K-1) && (k%W >= K-1);
      n_checks++; if (cyc_ov[acc_cyc[k]+1] !== want) $display("FAIL stream_ovalid_after_px%0d got %b want %b", k, cyc_ov[acc_cyc[k]+1], want); else n_pass++;
    end
    n_checks++; if (acc_cyc.size() == W*H && acc_cyc[W*H-1] - acc_cyc[0] != W*H-1)
      $display("FAIL stream_throughput got %0d cycles want %0d", acc_cyc[W*H-1] - acc_cyc[0], W*H-1); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit to;
    set_ramp(); build_expected(); clear_rec();
    drive(W*H, 100, 100, 1, 5, to);
    n_checks++; if (to) $display("FAIL bp_timeout got timeout want done"); else n_pass++;
    n_checks++; if (stall_cyc < 0) $display("FAIL bp_stall_started got none want stall"); else n_pass++;
    if (stall_cyc >= 0) begin
      for (int j = 0; j <= 5; j++) begin
        n_checks++; if (cyc_ov[stall_cyc+j] !== 1'b1) $display("FAIL bp_ovalid_c%0d got %b want 1", j, cyc_ov[stall_cyc+j]); else n_pass++;
        n_checks++; if (cyc_dat[stall_cyc+j] !== exp_win[5]) $display("FAIL bp_odata_c%0d got %h want %h", j, cyc_dat[stall_cyc+j], exp_win[5]); else n_pass++;
        n_checks++; if (cyc_last[stall_cyc+j] !== exp_last[5]) $display("FAIL bp_olast_c%0d got %b want %b", j, cyc_last[stall_cyc+j], exp_last[5]); else n_pass++;
      end
      for (int j = 0; j < 5; j++) begin
        n_checks++; if (cyc_ird[stall_cyc+j] !== 1'b0) $display("FAIL bp_iready_c%0d got %b want 0", j, cyc_ird[stall_cyc+j]); else n_pass++;
      end
    end
    n_checks++; if (obs_win.size() != NW) $display("FAIL bp_count got %0d want %0d", obs_win.size(), NW); else n_pass++;
    for (int k = 0; k < obs_win.size() && k < NW; k++) begin
      n_checks++; if (obs_win[k] !== exp_win[k] || obs_last[k] !== exp_last[k])
        $display("FAIL bp_win%0d got %h/%b want %h/%b", k, obs_win[k], obs_last[k], exp_win[k], exp_last[k]); else n_pass++;
    end
  endtask

  task automatic test_row_wrap();
    bit to;
    logic [OW-1:0] w5;
    set_random(); build_expected(); clear_rec();
    drive(W*H, 100, 100, 1, -1, to);
    n_checks++; if (to) $display("FAIL wrap_timeout got timeout want done"); else n_pass++;
    for (int k = 0; k < acc_cyc.size(); k++) begin
      if (k/W >= K-1 && k%W < K-1) begin
        n_checks++; if (cyc_ov[acc_cyc[k]+1] !== 1'b0) $display("FAIL wrap_ovalid_r%0dc%0d got %b want 0", k/W, k%W, cyc_ov[acc_cyc[k]+1]); else n_pass++;
      end
    end
    w5 = (obs_win.size() > 5) ? obs_win[5] : 'x;
    for (int c = 0; c < K; c++) begin
      n_checks++; if (w5[c*DW +: DW] !== stored(img[1][c])) $display("FAIL wrap_r4c3_elem%0d got %h want %h", c, w5[c*DW +: DW], stored(img[1][c])); else n_pass++;
    end
    n_checks++; if (obs_win.size() != NW) $display("FAIL wrap_count got %0d want %0d", obs_win.size(), NW); else n_pass++;
    for (int k = 0; k < obs_win.size() && k < NW; k++) begin
      n_checks++; if (obs_win[k] !== exp_win[k]) $display("FAIL wrap_win%0d got %h want %h", k, obs_win[k], exp_win[k]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit to1, to2;
    set_random(); build_expected(); clear_rec();
    drive(W*H, 70, 60, 0, -1, to1);
    drive(W*H, 70, 60, 1, -1, to2);
    n_checks++; if (to1 || to2) $display("FAIL b2b_timeout got timeout want done"); else n_pass++;
    n_checks++; if (obs_win.size() != 2*NW) $display("FAIL b2b_count got %0d want %0d", obs_win.size(), 2*NW); else n_pass++;
    for (int k = 0; k < obs_win.size() && k < 2*NW; k++) begin
      n_checks++; if (obs_win[k] !== exp_win[k%NW] || obs_last[k] !== exp_last[k%NW])
        $display("FAIL b2b_win%0d got %h/%b want %h/%b", k, obs_win[k], obs_last[k], exp_win[k%NW], exp_last[k%NW]); else n_pass++;
    end
    for (int k = 0; k < acc_cyc.size(); k++) begin
      bit want;
      want = ((k%(W*H))/W >= K-1) && (k%W >= K-1);
      n_checks++; if (cyc_ov[acc_cyc[k]+1] !== want) $display("FAIL b2b_ovalid_after_px%0d got %b want %b", k, cyc_ov[acc_cyc[k]+1], want); else n_pass++;
    end
    n_checks++; if (acc_cyc.size() != 2*W*H || cyc_ov[acc_cyc[W*H+27]+1] !== 1'b1)
      $display("FAIL b2b_frame2_first_window got accepts=%0d want ovalid after accept 28", acc_cyc.size()); else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit to;
    set_ramp(); clear_rec();
    drive(20, 100, 100, 0, -1, to);
    n_checks++; if (to) $display("FAIL mrst_timeout got timeout want done"); else n_pass++;
    #2 rstn = 0;
    #1;
    n_checks++; if (ovalid !== 1'b0) $display("FAIL mrst_ovalid got %b want 0", ovalid); else n_pass++;
    n_checks++; if (odata !== '0) $display("FAIL mrst_odata got %h want 0", odata); else n_pass++;
    n_checks++; if (olast !== 1'b0) $display("FAIL mrst_olast got %b want 0", olast); else n_pass++;
    n_checks++; if (iready !== 1'b1) $display("FAIL mrst_iready got %b want 1", iready); else n_pass++;
    @(negedge clk);
    rstn = 1;
    build_expected(); clear_rec();
    drive(W*H, 100, 100, 1, -1, to);
    n_checks++; if (to) $display("FAIL mrst_frame_timeout got timeout want done"); else n_pass++;
    n_checks++; if (obs_win.size() != NW) $display("FAIL mrst_count got %0d want %0d", obs_win.size(), NW); else n_pass++;
    for (int k = 0; k < obs_win.size() && k < NW; k++) begin
      n_checks++; if (obs_win[k] !== exp_win[k] || obs_last[k] !== exp_last[k])
        $display("FAIL mrst_win%0d got %h/%b want %h/%b", k, obs_win[k], obs_last[k], exp_win[k], exp_last[k]); else n_pass++;
    end
  endtask

  task automatic test_clamp();
    bit to;
    logic [OW-1:0] w0;
    logic [DW-1:0] want15;
`ifdef CONV_WIN_CLAMP_EN
    want15 = 4'b1001;
`else
    want15 = 4'b1000;
`endif
    set_ramp();
    img[3][3] = 4'sb1000;
    build_expected(); clear_rec();
    drive(W*H, 100, 100, 1, -1, to);
    n_checks++; if (to) $display("FAIL clamp_timeout got timeout want done"); else n_pass++;
    w0 = (obs_win.size() > 0) ? obs_win[0] : 'x;
    n_checks++; if (w0[15*DW +: DW] !== want15) $display("FAIL clamp_elem15 got %b want %b", w0[15*DW +: DW], want15); else n_pass++;
    n_checks++; if (obs_win.size() != NW) $display("FAIL clamp_count got %0d want %0d", obs_win.size(), NW); else n_pass++;
    for (int k = 0; k < obs_win.size() && k < NW; k++) begin
      n_checks++; if (obs_win[k] !== exp_win[k]) $display("FAIL clamp_win%0d got %h want %h", k, obs_win[k], exp_win[k]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_row_wrap();
    test_back_to_back();
    test_mid_reset();
    test_clamp();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no finish want finish by 400000");
    $fatal(1, "watchdog expired");
  end

endmodule
